// File: rtl/board_raster.sv
`default_nettype none
// ============================================================================
// Module   : board_raster
// Purpose  : 10x20 playfield occupancy store with row-collapse engine and a
//            2-stage raster pipeline producing is_block / is_grid per pixel.
// Revision : 1.0
// ============================================================================
module board_raster #(
    parameter int X0        = 240,
    parameter int Y0        = 80,
    parameter int CELL_LOG2 = 4,
    parameter int COLS      = 10,
    parameter int ROWS      = 20
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [9:0]      DrawX,
    input  logic [9:0]      DrawY,
    input  logic            wr_en,
    input  logic [4:0]      wr_row,
    input  logic [3:0]      wr_col,
    input  logic            wr_data,
    input  logic            clr_req,
    input  logic [4:0]      clr_row,
    output logic            busy,
    output logic [ROWS-1:0] row_full,
    output logic            is_block,
    output logic            is_grid,
    output logic [9:0]      DrawX_d,
    output logic [9:0]      DrawY_d
);

    localparam logic [9:0] c_x_first = 10'(X0);
    localparam logic [9:0] c_y_first = 10'(Y0);
    localparam logic [9:0] c_x_span  = 10'(COLS << CELL_LOG2);
    localparam logic [9:0] c_y_span  = 10'(ROWS << CELL_LOG2);
    localparam logic [4:0] c_rows    = 5'(ROWS);
    localparam logic [3:0] c_cols    = 4'(COLS);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    // ------------------------------------------------------------------
    // Collapse FSM and board storage
    // ------------------------------------------------------------------
    logic [0:0]                 state_q, state_d;
    logic [4:0]                 p_q, p_d;
    logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
    logic                       w_wr_ok;
    logic                       w_clr_ok;
    logic                       busy_w;

    assign w_wr_ok  = (state_q == c_st_idle) && wr_en
                      && (wr_row < c_rows) && (wr_col < c_cols);
    assign w_clr_ok = (state_q == c_st_idle) && clr_req && (clr_row < c_rows);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (w_clr_ok) state_d = c_st_shift;
            c_st_shift: if (p_q == 5'd0) state_d = c_st_idle;
            default:    state_d = c_st_idle;
        endcase
    end

    always_comb begin
        busy_w = (state_q == c_st_shift);
    end

    assign busy = busy_w;

    // A simultaneous write and clear both apply in IDLE: the write lands now,
    // the first shift step runs next cycle on the updated board.
    always_comb begin
        board_d = board_q;
        p_d     = p_q;
        if (state_q == c_st_idle) begin
            if (w_wr_ok) begin
                board_d[wr_row][wr_col] = wr_data;
            end
            if (w_clr_ok) begin
                p_d = clr_row;
            end
        end else begin
            if (p_q != 5'd0) begin
                board_d[p_q] = board_q[p_q - 5'd1];
                p_d          = p_q - 5'd1;
            end else begin
                board_d[0] = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            board_q <= '0;
            p_q     <= 5'd0;
        end else begin
            board_q <= board_d;
            p_q     <= p_d;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row_full
        assign row_full[r] = &board_q[r];
    end

    // ------------------------------------------------------------------
    // Raster pipeline, stage 1: board-relative coordinates and area tests
    // ------------------------------------------------------------------
    logic [9:0] w_rx;
    logic [9:0] w_ry;
    logic       w_x_ge;
    logic       w_y_ge;
    logic       w_in_area;
    logic       w_in_cell;

    logic       s1_in_cell_q, s1_in_cell_d;
    logic       s1_on_line_q, s1_on_line_d;
    logic [3:0] s1_col_q,     s1_col_d;
    logic [4:0] s1_row_q,     s1_row_d;
    logic [9:0] s1_x_q,       s1_x_d;
    logic [9:0] s1_y_q,       s1_y_d;

    assign w_rx   = DrawX - c_x_first;
    assign w_ry   = DrawY - c_y_first;
    assign w_x_ge = (DrawX >= c_x_first);
    assign w_y_ge = (DrawY >= c_y_first);

    // The area range is one pixel wider than the cell range so the right
    // and bottom border lines are drawn.
    assign w_in_area = w_x_ge && w_y_ge && (w_rx <= c_x_span) && (w_ry <= c_y_span);
    assign w_in_cell = w_x_ge && w_y_ge && (w_rx <  c_x_span) && (w_ry <  c_y_span);

    always_comb begin
        s1_in_cell_d = w_in_cell;
        s1_on_line_d = w_in_area && ((w_rx[CELL_LOG2-1:0] == '0)
                                  || (w_ry[CELL_LOG2-1:0] == '0));
        // Indices are forced to zero off-board so a wrapped rx/ry can never
        // address a row or column outside the playfield.
        s1_col_d     = w_in_cell ? w_rx[CELL_LOG2 +: 4] : 4'd0;
        s1_row_d     = w_in_cell ? w_ry[CELL_LOG2 +: 5] : 5'd0;
        s1_x_d       = DrawX;
        s1_y_d       = DrawY;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_in_cell_q <= 1'b0;
            s1_on_line_q <= 1'b0;
            s1_col_q     <= 4'd0;
            s1_row_q     <= 5'd0;
            s1_x_q       <= 10'd0;
            s1_y_q       <= 10'd0;
        end else begin
            s1_in_cell_q <= s1_in_cell_d;
            s1_on_line_q <= s1_on_line_d;
            s1_col_q     <= s1_col_d;
            s1_row_q     <= s1_row_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Raster pipeline, stage 2: board lookup against the live board
    // ------------------------------------------------------------------
    logic       is_block_q, is_block_d;
    logic       is_grid_q,  is_grid_d;
    logic [9:0] x_d_q,      x_d_d;
    logic [9:0] y_d_q,      y_d_d;

    always_comb begin
        is_block_d = s1_in_cell_q && board_q[s1_row_q][s1_col_q];
        is_grid_d  = s1_on_line_q;
        x_d_d      = s1_x_q;
        y_d_d      = s1_y_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_block_q <= 1'b0;
            is_grid_q  <= 1'b0;
            x_d_q      <= 10'd0;
            y_d_q      <= 10'd0;
        end else begin
            is_block_q <= is_block_d;
            is_grid_q  <= is_grid_d;
            x_d_q      <= x_d_d;
            y_d_q      <= y_d_d;
        end
    end

    assign is_block = is_block_q;
    assign is_grid  = is_grid_q;
    assign DrawX_d  = x_d_q;
    assign DrawY_d  = y_d_q;

endmodule
`default_nettype wire

// File: tb/tb_board_raster.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_raster
// Purpose  : Directed self-checking bench for board_raster.
// Revision : 1.0
// ============================================================================
module tb_board_raster;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        wr_en;
    logic [4:0]  wr_row;
    logic [3:0]  wr_col;
    logic        wr_data;
    logic        clr_req;
    logic [4:0]  clr_row;
    logic        busy;
    logic [19:0] row_full;
    logic        is_block, is_grid;
    logic [9:0]  DrawX_d, DrawY_d;

    int total = 0;
    int bad   = 0;

    int sweep_ys[13] = '{0, 79, 80, 81, 88, 95, 96, 239, 390, 399, 400, 401, 479};
    int sweep_xs[11] = '{0, 239, 240, 241, 248, 255, 256, 399, 400, 401, 639};

    always #5 Clk = ~Clk;

    board_raster dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_row  (clr_row),
        .busy     (busy),
        .row_full (row_full),
        .is_block (is_block),
        .is_grid  (is_grid),
        .DrawX_d  (DrawX_d),
        .DrawY_d  (DrawY_d)
    );

    function automatic logic exp_grid(input int x, input int y);
        if (x < 240 || x > 400 || y < 80 || y > 400) return 1'b0;
        return (((x - 240) % 16) == 0) || (((y - 80) % 16) == 0);
    endfunction

    // All tasks begin and end on a falling edge.
    task automatic probe(input int x, input int y, output logic blk, output logic grd);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        @(negedge Clk);
        blk = is_block;
        grd = is_grid;
    endtask

    task automatic write_cell(input int r, input int c, input logic d);
        wr_row  = 5'(r);
        wr_col  = 4'(c);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge Clk);
        wr_en   = 1'b0;
    endtask

    task automatic write_row(input int r, input logic [9:0] v);
        for (int c = 0; c < 10; c++) write_cell(r, c, v[c]);
    endtask

    task automatic read_row(input int r, output logic [9:0] v);
        logic b, g;
        for (int c = 0; c < 10; c++) begin
            probe(248 + 16 * c, 88 + 16 * r, b, g);
            v[c] = b;
        end
    endtask

    task automatic start_clear(input int r);
        clr_row = 5'(r);
        clr_req = 1'b1;
        @(negedge Clk);
        clr_req = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic sweep_line(input bit vertical, input int fixed);
        int n, errs, bx, by;
        int hx[$], hy[$];
        n    = vertical ? 480 : 640;
        errs = 0;
        bx   = -1;
        by   = -1;
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                int ex, ey;
                ex = hx.pop_front();
                ey = hy.pop_front();
                if (is_block !== 1'b0 || is_grid !== exp_grid(ex, ey)
                    || DrawX_d !== 10'(ex) || DrawY_d !== 10'(ey)) begin
                    if (errs == 0) begin bx = ex; by = ey; end
                    errs++;
                end
            end
            if (i < n) begin
                int px, py;
                px = vertical ? fixed : i;
                py = vertical ? i : fixed;
                DrawX = 10'(px);
                DrawY = 10'(py);
                hx.push_back(px);
                hy.push_back(py);
            end
            @(negedge Clk);
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL sweep %s=%0d: %0d bad pixels, required 0 (first at x=%0d y=%0d)",
                     vertical ? "x" : "y", fixed, errs, bx, by);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        DrawX = 10'd240; DrawY = 10'd80;
        repeat (3) @(negedge Clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (row_full !== 20'h0) begin bad++; $display("FAIL reset_row_full got=%h exp=0", row_full); end
        total++; if (is_block !== 1'b0) begin bad++; $display("FAIL reset_is_block got=%b exp=0", is_block); end
        total++; if (is_grid !== 1'b0) begin bad++; $display("FAIL reset_is_grid got=%b exp=0", is_grid); end
        total++; if (DrawX_d !== 10'd0 || DrawY_d !== 10'd0) begin
            bad++; $display("FAIL reset_draw_d got=%0d,%0d exp=0,0", DrawX_d, DrawY_d);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_frame_sweep();
        foreach (sweep_ys[i]) sweep_line(1'b0, sweep_ys[i]);
        foreach (sweep_xs[i]) sweep_line(1'b1, sweep_xs[i]);
    endtask

    task automatic test_block_pixel();
        logic b, g;
        write_cell(19, 0, 1'b1);
        probe(245, 390, b, g);
        total++; if (b !== 1'b1 || g !== 1'b0) begin
            bad++; $display("FAIL pix_245_390 got blk=%b grid=%b exp blk=1 grid=0", b, g);
        end
        probe(240, 390, b, g);
        total++; if (g !== 1'b1) begin bad++; $display("FAIL pix_240_390 grid got=%b exp=1", g); end
        probe(261, 390, b, g);
        total++; if (b !== 1'b0) begin bad++; $display("FAIL pix_261_390 blk got=%b exp=0", b); end
        total++; if (DrawX_d !== 10'd261 || DrawY_d !== 10'd390) begin
            bad++; $display("FAIL pix_draw_d got=%0d,%0d exp=261,390", DrawX_d, DrawY_d);
        end
    endtask

    task automatic test_row_full();
        for (int c = 1; c < 10; c++) write_cell(19, c, 1'b1);
        total++; if (row_full !== 20'h80000) begin bad++; $display("FAIL row_full_set got=%h exp=80000", row_full); end
        write_cell(19, 4, 1'b0);
        total++; if (row_full !== 20'h00000) begin bad++; $display("FAIL row_full_clr got=%h exp=00000", row_full); end
    endtask

    task automatic test_collapse();
        int cnt;
        logic [9:0] v;
        write_row(17, 10'h3FF);
        write_row(18, 10'h001);
        write_row(19, 10'h3FF);
        total++; if (row_full !== 20'hA0000) begin bad++; $display("FAIL preset_row_full got=%h exp=a0000", row_full); end
        start_clear(19);
        count_busy(cnt);
        total++; if (cnt !== 20) begin bad++; $display("FAIL collapse_busy_cycles got=%0d exp=20", cnt); end
        read_row(19, v);
        total++; if (v !== 10'h001) begin bad++; $display("FAIL collapse_row19 got=%h exp=001", v); end
        read_row(18, v);
        total++; if (v !== 10'h3FF) begin bad++; $display("FAIL collapse_row18 got=%h exp=3ff", v); end
        read_row(17, v);
        total++; if (v !== 10'h000) begin bad++; $display("FAIL collapse_row17 got=%h exp=000", v); end
        read_row(0, v);
        total++; if (v !== 10'h000) begin bad++; $display("FAIL collapse_row0 got=%h exp=000", v); end
        total++; if (row_full !== 20'h40000) begin bad++; $display("FAIL collapse_row_full got=%h exp=40000", row_full); end
    endtask

    task automatic test_busy_ignore();
        int cnt;
        logic [9:0] v;
        start_clear(18);
        cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            wr_en   = (cnt == 2);
            wr_row  = 5'd0; wr_col = 4'd0; wr_data = 1'b1;
            clr_req = (cnt == 2);
            clr_row = 5'd19;
            cnt++;
            @(negedge Clk);
        end
        wr_en = 1'b0; clr_req = 1'b0;
        total++; if (cnt !== 19) begin bad++; $display("FAIL busy_ignore_cycles got=%0d exp=19", cnt); end
        @(negedge Clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
        for (int r = 0; r < 20; r++) begin
            read_row(r, v);
            total++;
            if (v !== ((r == 19) ? 10'h001 : 10'h000)) begin
                bad++; $display("FAIL busy_ignore_row%0d got=%h exp=%h", r, v, (r == 19) ? 10'h001 : 10'h000);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [9:0] v;
        write_cell(20, 0, 1'b1);
        write_cell(0, 10, 1'b1);
        write_cell(31, 15, 1'b1);
        clr_row = 5'd20; clr_req = 1'b1;
        @(negedge Clk);
        clr_row = 5'd31;
        @(negedge Clk);
        clr_req = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL oor_clear_busy got=%b exp=0", busy); end
        read_row(0, v);
        total++; if (v !== 10'h000) begin bad++; $display("FAIL oor_row0 got=%h exp=000", v); end
        read_row(19, v);
        total++; if (v !== 10'h001) begin bad++; $display("FAIL oor_row19 got=%h exp=001", v); end
        total++; if (row_full !== 20'h0) begin bad++; $display("FAIL oor_row_full got=%h exp=0", row_full); end
    endtask

    task automatic test_simultaneous();
        int cnt;
        logic [9:0] v;
        wr_row = 5'd18; wr_col = 4'd3; wr_data = 1'b1; wr_en = 1'b1;
        clr_row = 5'd19; clr_req = 1'b1;
        @(negedge Clk);
        wr_en = 1'b0; clr_req = 1'b0;
        count_busy(cnt);
        total++; if (cnt !== 20) begin bad++; $display("FAIL simul_busy_cycles got=%0d exp=20", cnt); end
        read_row(19, v);
        total++; if (v !== 10'h008) begin bad++; $display("FAIL simul_row19 got=%h exp=008", v); end
        read_row(18, v);
        total++; if (v !== 10'h000) begin bad++; $display("FAIL simul_row18 got=%h exp=000", v); end
    endtask

    task automatic test_async_reset();
        int cnt;
        logic [9:0] v;
        write_row(10, 10'h3FF);
        total++; if (row_full !== 20'h00400) begin bad++; $display("FAIL ar_preset_row_full got=%h exp=00400", row_full); end
        DrawX = 10'd240; DrawY = 10'd80;
        start_clear(19);
        repeat (12) @(negedge Clk);
        total++; if (busy !== 1'b1 || row_full !== 20'h00800 || is_grid !== 1'b1 || DrawX_d !== 10'd240) begin
            bad++; $display("FAIL ar_mid_shift got busy=%b full=%h grid=%b xd=%0d exp 1,00800,1,240",
                            busy, row_full, is_grid, DrawX_d);
        end
        #2 Reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
        total++; if (row_full !== 20'h0) begin bad++; $display("FAIL ar_row_full got=%h exp=0", row_full); end
        total++; if (is_grid !== 1'b0 || is_block !== 1'b0) begin
            bad++; $display("FAIL ar_pixel got grid=%b blk=%b exp 0,0", is_grid, is_block);
        end
        total++; if (DrawX_d !== 10'd0 || DrawY_d !== 10'd0) begin
            bad++; $display("FAIL ar_draw_d got=%0d,%0d exp=0,0", DrawX_d, DrawY_d);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        read_row(19, v);
        total++; if (v !== 10'h000 || busy !== 1'b0) begin
            bad++; $display("FAIL ar_after_row19 got=%h busy=%b exp=000,0", v, busy);
        end
        write_cell(0, 0, 1'b1);
        read_row(0, v);
        total++; if (v !== 10'h001) begin bad++; $display("FAIL ar_write_row0 got=%h exp=001", v); end
        start_clear(0);
        count_busy(cnt);
        total++; if (cnt !== 1) begin bad++; $display("FAIL ar_clear0_cycles got=%0d exp=1", cnt); end
        read_row(0, v);
        total++; if (v !== 10'h000) begin bad++; $display("FAIL ar_clear0_row0 got=%h exp=000", v); end
    endtask

    initial begin
        Reset_n = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        wr_en = 1'b0; wr_row = 5'd0; wr_col = 4'd0; wr_data = 1'b0;
        clr_req = 1'b0; clr_row = 5'd0;
        @(negedge Clk);
        test_reset();
        test_frame_sweep();
        test_block_pixel();
        test_row_full();
        test_collapse();
        test_busy_ignore();
        test_out_of_range();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
